hex_word_scroller: RTL and testbench

Parametrised, self-timed successor to the switch-selected three-digit "dE1" rotator. It holds a message of MSG_LEN 2-bit character codes and shows a NUM_DIGITS-wide window of it on active-low seven-segment displays. The window scrolls left or right on a prescaled tick, or one position per manual step while paused. It sits between the board switches/keys and the HEX outputs at the top level of a lab design.

---
 rtl/scroller_pkg.sv | 34 +++
 rtl/hex_char_decoder.sv | 16 +
 rtl/hex_word_scroller.sv | 145 ++++++++++++++
 tb/tb_hex_word_scroller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scroller_pkg.sv
// scroller_pkg: shared constants for the hex_word_scroller display block.
// Holds the 2-bit character codes, their active-low seven-segment patterns
// and the code-to-pattern helper used by hex_char_decoder.
package scroller_pkg;

  // Width of one message character code
  localparam int CHAR_W = 2;

  // Character codes as they appear in the MSG input
  localparam logic [1:0] CH_D     = 2'b00;
  localparam logic [1:0] CH_E     = 2'b01;
  localparam logic [1:0] CH_1     = 2'b10;
  localparam logic [1:0] CH_BLANK = 2'b11;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Map a character code to its segment pattern; unknown codes go blank
  function automatic logic [6:0] char_to_seg(input logic [CHAR_W-1:0] code);
    logic [6:0] seg;
    case (code)
      CH_D:     seg = SEG_D;
      CH_E:     seg = SEG_E;
      CH_1:     seg = SEG_1;
      CH_BLANK: seg = SEG_BLANK;
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_char_decoder.sv
// hex_char_decoder: purely combinational 2-bit character code to
// active-low seven-segment pattern. One instance per displayed digit.
module hex_char_decoder
  import scroller_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  // Translate the character code into its segment pattern
  always_comb begin
    seg = SEG_BLANK;
    seg = char_to_seg(code);
  end

endmodule

// File: rtl/hex_word_scroller.sv
// hex_word_scroller: shows a NUM_DIGITS-wide window of a MSG_LEN-character
// ring on active-low seven-segment digits and scrolls it left or right on a
// prescaled tick, or one position per STEP rising edge while paused.
// Optional feature macro: SCROLLER_STEP_EN (manual step edge detector).
// With the macro undefined the STEP port is present but has no effect.
module hex_word_scroller
  import scroller_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 4,
  parameter int TICK_DIV   = 50_000_000,
  localparam int POS_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      EN,
  input  logic                      DIR,
  input  logic                      STEP,
  input  logic [MSG_LEN*CHAR_W-1:0] MSG,
  output logic [NUM_DIGITS*7-1:0]   HEX_OUT,
  output logic [POS_W-1:0]          POS,
  output logic                      TICK
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);
  // Index arithmetic is done 6 bits wide: max POS 15 plus max offset 7
  localparam int SUM_W = 6;
  localparam int IDX_W = 5;

  logic [PRE_W-1:0]        pre_r;
  logic [PRE_W-1:0]        pre_nxt_s;
  logic [POS_W-1:0]        pos_r;
  logic [POS_W-1:0]        pos_nxt_s;
  logic                    tick_r;
  logic                    adv_s;
  logic                    step_adv_s;
  logic [NUM_DIGITS*7-1:0] hex_r;
  logic [NUM_DIGITS*7-1:0] frame_s;

`ifdef SCROLLER_STEP_EN
  logic step_q_r;

  // Remember last STEP level so only its rising edge requests an advance
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      step_q_r <= 1'b0;
    end else begin
      step_q_r <= STEP;
    end
  end

  // A step edge only counts while auto-scroll is paused; EN wins a tie
  assign step_adv_s = STEP & ~step_q_r & ~EN;
`else
  logic unused_step_s;

  // Manual stepping is not built; the key input is deliberately ignored
  assign unused_step_s = STEP;
  assign step_adv_s    = 1'b0;
`endif

  // Prescaler: counts while enabled, holds while paused, fires at terminal
  always_comb begin
    pre_nxt_s = pre_r;
    adv_s     = 1'b0;
    if (EN) begin
      if (pre_r == PRE_LAST) begin
        pre_nxt_s = {PRE_W{1'b0}};
        adv_s     = 1'b1;
      end else begin
        pre_nxt_s = pre_r + PRE_W'(1);
        adv_s     = 1'b0;
      end
    end else begin
      pre_nxt_s = pre_r;
      adv_s     = step_adv_s;
    end
  end

  // Window start update; DIR only matters on the advance cycle
  always_comb begin
    pos_nxt_s = pos_r;
    if (adv_s) begin
      if (DIR) begin
        if (pos_r == {POS_W{1'b0}}) begin
          pos_nxt_s = POS_LAST;
        end else begin
          pos_nxt_s = pos_r - POS_W'(1);
        end
      end else begin
        if (pos_r == POS_LAST) begin
          pos_nxt_s = {POS_W{1'b0}};
        end else begin
          pos_nxt_s = pos_r + POS_W'(1);
        end
      end
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  // Per-digit character selection and decode of the current window
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [SUM_W-1:0]  sum_s;
    logic [IDX_W-1:0]  idx_s;
    logic [CHAR_W-1:0] code_s;
    logic [6:0]        seg_s;

    // Leftmost digit shows character POS; repeats when digits exceed MSG_LEN
    always_comb begin
      sum_s  = SUM_W'(pos_r) + SUM_W'(NUM_DIGITS - 1 - d);
      idx_s  = IDX_W'(sum_s % SUM_W'(MSG_LEN));
      code_s = MSG[CHAR_W*idx_s +: CHAR_W];
    end

    hex_char_decoder u_dec (
      .code (code_s),
      .seg  (seg_s)
    );

    assign frame_s[7*d +: 7] = seg_s;
  end

  // State and output registers; reset blanks the display and parks POS at 0
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pre_r  <= {PRE_W{1'b0}};
      pos_r  <= {POS_W{1'b0}};
      tick_r <= 1'b0;
      hex_r  <= {(NUM_DIGITS*7){1'b1}};
    end else begin
      pre_r  <= pre_nxt_s;
      pos_r  <= pos_nxt_s;
      tick_r <= adv_s;
      hex_r  <= frame_s;
    end
  end

  assign HEX_OUT = hex_r;
  assign POS     = pos_r;
  assign TICK    = tick_r;

endmodule

// File: tb/tb_hex_word_scroller.sv
// tb_hex_word_scroller: directed, table-driven bench for hex_word_scroller.
// Main instance: NUM_DIGITS=3, MSG_LEN=4, TICK_DIV=4, MSG = d,E,1,blank.
// Second instance: NUM_DIGITS=2, MSG_LEN=1, TICK_DIV=3, MSG = E.
module tb_hex_word_scroller;

  // Hand-written segment patterns (active low)
  localparam logic [6:0] S_D = 7'b0100001;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_1 = 7'b1001111;
  localparam logic [6:0] S_B = 7'b1111111;

  // Expected frames, HEX2..HEX0 left to right, for POS 0..3
  localparam logic [20:0] F0 = {S_D, S_E, S_1};
  localparam logic [20:0] F1 = {S_E, S_1, S_B};
  localparam logic [20:0] F2 = {S_1, S_B, S_D};
  localparam logic [20:0] F3 = {S_B, S_D, S_E};
  localparam logic [20:0] FBLANK = {S_B, S_B, S_B};

  logic        clk = 1'b0;
  logic        reset, en, dir, stp;
  logic [7:0]  msg;
  logic [20:0] hex;
  logic [1:0]  pos;
  logic        tick;

  logic        reset1, en1;
  logic [1:0]  msg1;
  logic [13:0] hex1;
  logic [0:0]  pos1;
  logic        tick1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_word_scroller #(.NUM_DIGITS(3), .MSG_LEN(4), .TICK_DIV(4)) u_dut (
    .CLOCK_50 (clk),
    .RESET    (reset),
    .EN       (en),
    .DIR      (dir),
    .STEP     (stp),
    .MSG      (msg),
    .HEX_OUT  (hex),
    .POS      (pos),
    .TICK     (tick)
  );

  hex_word_scroller #(.NUM_DIGITS(2), .MSG_LEN(1), .TICK_DIV(3)) u_dut1 (
    .CLOCK_50 (clk),
    .RESET    (reset1),
    .EN       (en1),
    .DIR      (1'b0),
    .STEP     (1'b0),
    .MSG      (msg1),
    .HEX_OUT  (hex1),
    .POS      (pos1),
    .TICK     (tick1)
  );

  typedef struct {
    logic        en;
    logic        dir;
    logic [1:0]  pos;
    logic        tick;
    logic [20:0] hex;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic e, input logic d, input logic [1:0] p,
                              input logic t, input logic [20:0] h);
    vec_t v;
    v.en = e; v.dir = d; v.pos = p; v.tick = t; v.hex = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int tick_cnt;
  int bad_cnt;
  int base;
  bit found;

  initial begin
    // Left scroll from POS 0, PRE 0, frame F0 already loaded
    vecs[0]  = mk(1'b1, 1'b0, 2'd0, 1'b0, F0);
    vecs[1]  = mk(1'b1, 1'b0, 2'd0, 1'b0, F0);
    vecs[2]  = mk(1'b1, 1'b0, 2'd0, 1'b0, F0);
    vecs[3]  = mk(1'b1, 1'b0, 2'd1, 1'b1, F0);
    vecs[4]  = mk(1'b1, 1'b0, 2'd1, 1'b0, F1);
    vecs[5]  = mk(1'b1, 1'b0, 2'd1, 1'b0, F1);
    vecs[6]  = mk(1'b1, 1'b0, 2'd1, 1'b0, F1);
    vecs[7]  = mk(1'b1, 1'b0, 2'd2, 1'b1, F1);
    vecs[8]  = mk(1'b1, 1'b0, 2'd2, 1'b0, F2);
    vecs[9]  = mk(1'b1, 1'b0, 2'd2, 1'b0, F2);
    vecs[10] = mk(1'b1, 1'b0, 2'd2, 1'b0, F2);
    vecs[11] = mk(1'b1, 1'b0, 2'd3, 1'b1, F2);
    vecs[12] = mk(1'b1, 1'b0, 2'd3, 1'b0, F3);
    vecs[13] = mk(1'b1, 1'b0, 2'd3, 1'b0, F3);
    vecs[14] = mk(1'b1, 1'b0, 2'd3, 1'b0, F3);
    vecs[15] = mk(1'b1, 1'b0, 2'd0, 1'b1, F3);
    // Right scroll from POS 0, PRE 0: wraps to 3, then 2
    vecs[16] = mk(1'b1, 1'b1, 2'd0, 1'b0, F0);
    vecs[17] = mk(1'b1, 1'b1, 2'd0, 1'b0, F0);
    vecs[18] = mk(1'b1, 1'b1, 2'd0, 1'b0, F0);
    vecs[19] = mk(1'b1, 1'b1, 2'd3, 1'b1, F0);
    vecs[20] = mk(1'b1, 1'b1, 2'd3, 1'b0, F3);
    vecs[21] = mk(1'b1, 1'b1, 2'd3, 1'b0, F3);
    vecs[22] = mk(1'b1, 1'b1, 2'd3, 1'b0, F3);
    vecs[23] = mk(1'b1, 1'b1, 2'd2, 1'b1, F3);
    vecs[24] = mk(1'b1, 1'b1, 2'd2, 1'b0, F2);

    reset = 1'b1; en = 1'b0; dir = 1'b0; stp = 1'b0; msg = 8'b11_10_01_00;
    reset1 = 1'b1; en1 = 1'b0; msg1 = 2'b01;

    // Reset state
    cyc(); cyc();
    chk("reset_pos", 32'(pos), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_hex", 32'(hex), 32'(FBLANK));

    // First frame after release
    reset = 1'b0;
    cyc(); cyc();
    chk("first_frame", 32'(hex), 32'(F0));
    chk("first_pos", 32'(pos), 32'd0);

    // Table-driven auto scroll
    for (int i = 0; i < 25; i++) begin
      en  = vecs[i].en;
      dir = vecs[i].dir;
      cyc();
      chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(vecs[i].pos));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
      chk($sformatf("vec%0d_hex", i), 32'(hex), 32'(vecs[i].hex));
    end

    // Manual stepping while paused: high 5, low 2, high 5, low 2
    reset = 1'b1; en = 1'b0; dir = 1'b0; stp = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    tick_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      stp = (i < 5 || (i >= 7 && i < 12)) ? 1'b1 : 1'b0;
      cyc();
      if (tick === 1'b1) tick_cnt++;
    end
`ifdef SCROLLER_STEP_EN
    base = 2;
`else
    base = 0;
`endif
    chk("step_ticks", 32'(tick_cnt), 32'(base));
    chk("step_pos", 32'(pos), 32'(base));

    // Pause/resume: PRE reaches 3, pause 10 cycles, resume advances at once
    en = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_run_tick", 32'(tick), 32'd0);
    en = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tick === 1'b1) tick_cnt++;
    end
    chk("pause_ticks", 32'(tick_cnt), 32'd0);
    chk("pause_pos", 32'(pos), 32'(base));
    en = 1'b1;
    cyc();
    chk("resume_tick", 32'(tick), 32'd1);
    chk("resume_pos", 32'(pos), 32'((base + 1) % 4));

    // EN rising together with a STEP edge: the step is dropped
    en = 1'b0; stp = 1'b0;
    cyc();
    en = 1'b1; stp = 1'b1;
    cyc();
    chk("en_step_tick", 32'(tick), 32'd0);
    chk("en_step_pos", 32'(pos), 32'((base + 1) % 4));
    stp = 1'b0;

    // Reset in the middle of a scroll once POS reaches 2
    dir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (pos === 2'd2) found = 1'b1;
    end
    chk("reach_pos2", 32'(found), 32'd1);
    reset = 1'b1;
    cyc();
    chk("midreset_pos", 32'(pos), 32'd0);
    chk("midreset_tick", 32'(tick), 32'd0);
    chk("midreset_hex", 32'(hex), 32'(FBLANK));
    reset = 1'b0; en = 1'b0;

    // Single-character ring: POS stays 0, TICK every 3 cycles
    reset1 = 1'b0; en1 = 1'b1;
    tick_cnt = 0;
    bad_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (tick1 === 1'b1) tick_cnt++;
      if (pos1 !== 1'b0) bad_cnt++;
    end
    chk("len1_ticks", 32'(tick_cnt), 32'd3);
    chk("len1_pos", 32'(bad_cnt), 32'd0);
    chk("len1_hex", 32'(hex1), 32'({S_E, S_E}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
